// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- execute-stage ALU behind a valid/ready handshake.
//
// Consumes the 4-bit op code from the ALU control decoder plus two operands.
// The result, zero flag and illegal flag are registered. They stay valid until
// the consumer takes them.
//
// Single-cycle ops (AND, OR, ADD, SUB, SLT) write the result on the accept edge.
// MUL runs as a MUL_CYCLES-step shift-add sequence followed by one transfer edge.
// So out_valid rises MUL_CYCLES+1 edges after accept.
//
// Optional feature: define ALU_EXEC_MUL_EN to build the multiplier and the
// MUL_BUSY state. Without the macro, code 1000 is decoded as unsupported.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  operation handshake (alu_ctl, op_a, op_b)
//   out_valid / out_ready result handshake
//   result, zero, illegal registered outputs
module alu_exec_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  // op codes from the ALU control decoder
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
`ifdef ALU_EXEC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
`ifdef ALU_EXEC_MUL_EN
  localparam logic [1:0] S_BUSY = 2'd1;
`endif
  localparam logic [1:0] S_DONE = 2'd2;

  // registered output bundle
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
  } rsp_t;

  logic [1:0] state_q, state_d;
  rsp_t       rsp_q,   rsp_d;

  logic             accept;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ill;

`ifdef ALU_EXEC_MUL_EN
  localparam int CW = $clog2(MUL_CYCLES + 1);

  logic             is_mul;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
`endif

  // handshake
  // A held result blocks new work unless it is drained on this same edge.
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);

  assign result  = rsp_q.result;
  assign zero    = rsp_q.zero;
  assign illegal = rsp_q.illegal;

  // single-cycle datapath
  // Unlisted codes, including any code with x/z bits, fall to the default arm.
  // That arm returns result=0 and flags the op as illegal.
  always_comb begin
    sc_res = '0;
    sc_ill = 1'b0;
`ifdef ALU_EXEC_MUL_EN
    is_mul = 1'b0;
`endif
    case (alu_ctl)
      OP_AND:  sc_res = op_a & op_b;
      OP_OR:   sc_res = op_a | op_b;
      OP_ADD:  sc_res = op_a + op_b;
      OP_SUB:  sc_res = op_a - op_b;
      OP_SLT:  sc_res = WIDTH'($signed(op_a) < $signed(op_b));
`ifdef ALU_EXEC_MUL_EN
      OP_MUL:  is_mul = 1'b1;
`endif
      default: sc_ill = 1'b1;
    endcase
  end

  // next-state / next-output
  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
`ifdef ALU_EXEC_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
`ifdef ALU_EXEC_MUL_EN
          if (is_mul) begin
            // Operands are captured here; the bus is free to change afterwards.
            state_d  = S_BUSY;
            mcand_d  = op_a;
            mplier_d = op_b;
            acc_d    = '0;
            cnt_d    = '0;
          end else
`endif
          begin
            state_d       = S_DONE;
            rsp_d.result  = sc_res;
            rsp_d.zero    = (sc_res == '0);
            rsp_d.illegal = sc_ill;
          end
        end else if ((state_q == S_DONE) && out_ready) begin
          // Drain with no new work. The stale payload is left in place.
          state_d = S_IDLE;
        end
      end
`ifdef ALU_EXEC_MUL_EN
      S_BUSY: begin
        if (cnt_q == CW'(MUL_CYCLES)) begin
          // All iterations are done, so this edge publishes the product.
          state_d       = S_DONE;
          rsp_d.result  = acc_q;
          rsp_d.zero    = (acc_q == '0);
          rsp_d.illegal = 1'b0;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
    end
  end

`ifdef ALU_EXEC_MUL_EN
  // The multiply scratch is cleared too, so a reset mid-multiply leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit. Inputs change on the falling edge.
// Outputs are sampled 1 time unit after the rising edge.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_checks = 0;
  int n_err    = 0;

  alu_exec_unit #(.WIDTH(32), .MUL_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctl(alu_ctl), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = v;
    alu_ctl  = c;
    op_a     = a;
    op_b     = b;
  endtask

  initial begin
    int  edges;
    bit  seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctl = 4'b0000; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_result",    result,         32'd0);

    // A held ADD result is wiped by reset with no clock edge.
    out_ready = 1'b0;
    drive(1'b1, 4'b0010, 32'd5, 32'd3);
    step();
    check("hold_add_result", result, 32'd8);
    check("hold_in_ready",   32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_result",    result,         32'd0);
    check("async_rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b1;

    // ADD then SUB back-to-back with out_ready=1.
    out_ready = 1'b1;
    drive(1'b1, 4'b0010, 32'h5, 32'h3);
    step();
    check("add_result",    result, 32'h8);
    check("add_zero",      32'(zero), 32'd0);
    check("add_out_valid", 32'(out_valid), 32'd1);
    check("add_in_ready",  32'(in_ready), 32'd1);
    drive(1'b1, 4'b0110, 32'd7, 32'd7);
    step();
    check("sub_result",   result, 32'd0);
    check("sub_zero",     32'(zero), 32'd1);
    check("sub_in_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 4'b0000, 32'd0, 32'd0);
    step();
    check("drain_out_valid", 32'(out_valid), 32'd0);

    // SLT signed, then hold under back-pressure while a new op waits.
    out_ready = 1'b0;
    drive(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'h1);
    step();
    check("slt_neg_result", result, 32'd1);
    drive(1'b1, 4'b0111, 32'h1, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      step();
      check("slt_hold_result",   result, 32'd1);
      check("slt_hold_in_ready", 32'(in_ready), 32'd0);
      check("slt_hold_valid",    32'(out_valid), 32'd1);
    end
    @(negedge clk) out_ready = 1'b1;
    step();
    check("slt_swap_result", result, 32'd0);
    check("slt_swap_zero",   32'(zero), 32'd1);
    drive(1'b0, 4'b0000, 32'd0, 32'd0);
    step();

    // Unsupported codes, including x bits.
    drive(1'b1, 4'b0011, 32'd5, 32'd9);
    step();
    check("ill_result",  result, 32'd0);
    check("ill_zero",    32'(zero), 32'd1);
    check("ill_flag",    32'(illegal), 32'd1);
    drive(1'b1, 4'b0010, 32'd1, 32'd1);
    step();
    check("post_ill_result", result, 32'd2);
    check("post_ill_flag",   32'(illegal), 32'd0);
    drive(1'b1, 4'b1x10, 32'd4, 32'd4);
    step();
    check("x_ctl_illegal", 32'(illegal), 32'd1);
    check("x_ctl_result",  result, 32'd0);

    // Reset clears zero/illegal as well.
    out_ready = 1'b0;
    drive(1'b1, 4'b0011, 32'd1, 32'd2);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("rst2_zero",    32'(zero), 32'd0);
    check("rst2_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b1; out_ready = 1'b1;

`ifdef ALU_EXEC_MUL_EN
    // MUL: out_valid appears 33 edges after accept; busy ignores in_valid.
    drive(1'b1, 4'b1000, 32'h0001_0001, 32'h0001_0001);
    step();
    check("mul_busy_in_ready0", 32'(in_ready), 32'd0);
    check("mul_busy_valid0",    32'(out_valid), 32'd0);
    drive(1'b1, 4'b0010, 32'd9, 32'd9);
    step();
    edges = 1;
    check("mul_busy_in_ready1", 32'(in_ready), 32'd0);
    @(negedge clk) in_valid = 1'b0;
    while (!out_valid && edges < 40) begin
      step();
      edges++;
    end
    check("mul_latency", 32'(edges), 32'd33);
    check("mul_result",  result, 32'h0002_0001);
    check("mul_illegal", 32'(illegal), 32'd0);
    step();

    // Abort a multiply at iteration 10.
    drive(1'b1, 4'b1000, 32'd3, 32'd5);
    step();
    @(negedge clk) in_valid = 1'b0;
    repeat (9) step();
`else
    // Without the multiplier, code 1000 is unsupported and finishes in one cycle.
    drive(1'b1, 4'b1000, 32'd3, 32'd5);
    step();
    check("nomul_illegal",  32'(illegal), 32'd1);
    check("nomul_result",   result, 32'd0);
    check("nomul_zero",     32'(zero), 32'd1);
    @(negedge clk) in_valid = 1'b0;
    step();
`endif
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready",  32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    drive(1'b1, 4'b0010, 32'd2, 32'd2);
    step();
    check("post_abort_add",   result, 32'd4);
    check("post_abort_valid", 32'(out_valid), 32'd1);
    @(negedge clk) in_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
